// File: rtl/bs_deserializer_if.sv
`default_nettype none
// ============================================================================
//  Module   : bs_deserializer_if
//  Brief    : Parallel word output bundle of the bit-serial deserializer
//             (head word, channel tag and valid/ready handshake).
//  Revision : 1.0 - initial release
// ============================================================================
interface bs_deserializer_if #(
  parameter int W = 24
);
  logic [W-1:0] out_data;
  logic         out_ch;
  logic         out_valid;
  logic         out_ready;

  // Producer side: the deserializer drives the word, the consumer drives ready.
  modport master (
    output out_data,
    output out_ch,
    output out_valid,
    input  out_ready
  );

  // Consumer side.
  modport slave (
    input  out_data,
    input  out_ch,
    input  out_valid,
    output out_ready
  );
endinterface
`default_nettype wire

// File: rtl/bs_deserializer.sv
`default_nettype none
// ============================================================================
//  Module   : bs_deserializer
//  Brief    : Receives a bclk/lrclk framed, LSB-first serial sample stream,
//             rebuilds W-bit words tagged with their channel and queues them
//             in a show-ahead FIFO behind a valid/ready interface.
//  Revision : 1.0 - initial release
// ============================================================================
module bs_deserializer #(
  parameter int W     = 24,
  parameter int DEPTH = 4
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic                     bclk,
  input  wire logic                     lrclk,
  input  wire logic                     in,
  output      logic [$clog2(DEPTH):0]   level,
  output      logic                     overflow,
  output      logic                     frame_err,
  input  wire logic                     clr_err,
  bs_deserializer_if.master             m_if
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = (W > 1) ? $clog2(W) : 1;
  localparam logic [c_cw-1:0] c_last  = c_cw'(W - 1);
  localparam logic [c_cw-1:0] c_one   = c_cw'(1);
  localparam logic [c_aw:0]   c_depth = (c_aw + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_UNSYNC = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Receiver state
  logic            r_bclk_q;
  logic            r_lr_q;
  state_t          r_state;
  logic [c_cw-1:0] r_cnt;
  logic [W-1:0]    r_word;

  // Receiver next-state / events
  state_t          w_state_nxt;
  logic [c_cw-1:0] w_cnt_nxt;
  logic [W-1:0]    w_word_nxt;
  logic            w_rise;
  logic            w_start;
  logic            w_push;
  logic            w_ferr_set;

  // FIFO state
  logic [W:0]      r_mem [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0]   r_count;

  logic            w_valid;
  logic            w_full;
  logic            w_pop;
  logic            w_wr_en;
  logic            w_ovf_set;
  logic [W:0]      w_head;

  assign w_rise  = bclk & ~r_bclk_q;
  assign w_start = (lrclk != r_lr_q);

  // Edge detect of bclk and lrclk level remembered at each bclk rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bclk_q <= 1'b0;
      r_lr_q   <= 1'b0;
    end else begin
      r_bclk_q <= bclk;
      if (w_rise) begin
        r_lr_q <= lrclk;
      end
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_UNSYNC;
      r_cnt   <= '0;
      r_word  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_word  <= w_word_nxt;
    end
  end

  // Slot framing: a slot start always begins a fresh word at bit 0; a start
  // that interrupts an unfinished word discards it and flags a framing error.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_word_nxt  = r_word;
    w_push      = 1'b0;
    w_ferr_set  = 1'b0;
    if (w_rise) begin
      if (w_start) begin
        w_ferr_set    = (r_state == ST_SHIFT);
        w_word_nxt    = '0;
        w_word_nxt[0] = in;
        w_cnt_nxt     = c_one;
        if (W == 1) begin
          w_push      = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end else if (r_state == ST_SHIFT) begin
        w_word_nxt[r_cnt] = in;
        if (r_cnt == c_last) begin
          w_push      = 1'b1;
          w_state_nxt = ST_DONE;
        end else begin
          w_cnt_nxt = r_cnt + c_one;
        end
      end
    end
  end

  assign w_valid   = (r_count != '0);
  assign w_full    = (r_count == c_depth);
  assign w_pop     = w_valid & m_if.out_ready;
  // When full, a simultaneous pop frees the head slot, which is exactly
  // where the write pointer sits, so the new word lands at the tail.
  assign w_wr_en   = w_push & (~w_full | w_pop);
  assign w_ovf_set = w_push & w_full & ~w_pop;

  // FIFO storage; contents need no reset because out_valid qualifies them.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= {lrclk, w_word_nxt};
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_wr_en && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_wr_en && w_pop) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Sticky error flags; a new error event wins over a clear request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (w_ferr_set) begin
        frame_err <= 1'b1;
      end else if (clr_err) begin
        frame_err <= 1'b0;
      end
    end
  end

  // Head word is forced to zero while empty so outputs are clean after reset.
  assign w_head         = w_valid ? r_mem[r_rd_ptr] : '0;
  assign m_if.out_data  = w_head[W-1:0];
  assign m_if.out_ch    = w_head[W];
  assign m_if.out_valid = w_valid;
  assign level          = r_count;

endmodule
`default_nettype wire
